// File: rtl/cache_controller_if.sv
// Bundle for the cache controller: CPU load/store request, cache array
// control and word-wide main-memory bus. master = controller side.
interface cache_controller_if #(
  parameter int DATA_W   = 32,
  parameter int LINE_W   = 128,
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  logic                req_valid;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_ready;
  logic [DATA_W-1:0]   req_rdata;

  logic                c_hit;
  logic [DATA_W-1:0]   c_rdata;
  logic [TAG_W-1:0]    c_tag;
  logic [INDEX_W-1:0]  c_index;
  logic [OFFSET_W-1:0] c_offset;
  logic                c_re;
  logic                c_refill;
  logic                c_update;
  logic [LINE_W-1:0]   c_line;
  logic [DATA_W-1:0]   c_wdata;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, req_rdata,
    input  c_hit, c_rdata,
    output c_tag, c_index, c_offset, c_re,
    output c_refill, c_update, c_line, c_wdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, req_rdata,
    output c_hit, c_rdata,
    input  c_tag, c_index, c_offset, c_re,
    input  c_refill, c_update, c_line, c_wdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped write-through cache sequencer (IDLE/WRITE/FETCH/FILL).
// Optional hit/miss counters enabled by defining CACHE_PERF_CNT_EN.
module cache_controller #(
  parameter int DATA_W   = 32,
  parameter int LINE_W   = 128,
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
`ifdef CACHE_PERF_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic clk,
  input  logic reset_n,
  cache_controller_if.master bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
`endif
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FETCH,
    S_FILL
  } state_t;

  state_t              r_state;
  logic [OFFSET_W-1:0] r_beat;
  logic [LINE_W-1:0]   r_line;

  logic w_idle;
  logic w_wr;
  logic w_fetch;
  logic w_load;
  logic w_hit_done;
  logic w_miss;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;

  assign w_idle  = (r_state == S_IDLE);
  assign w_wr    = (r_state == S_WRITE);
  assign w_fetch = (r_state == S_FETCH);
  assign w_load  = bus.req_valid & ~bus.req_we;

  assign w_hit_done = w_idle & w_load & bus.c_hit;
  assign w_miss     = w_idle & w_load & ~bus.c_hit;

  assign w_tag   = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign w_index = bus.req_addr[OFFSET_W +: INDEX_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_line  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_we) begin
            r_state <= S_WRITE;
          end else if (w_miss) begin
            r_state <= S_FETCH;
            r_beat  <= '0;
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) r_state <= S_IDLE;
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            r_line[int'(r_beat)*DATA_W +: DATA_W]
              <= bus.mem_rdata;
            r_beat <= r_beat + 1'b1;
            if (r_beat == '1) r_state <= S_FILL;
          end
        end
        S_FILL: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Loads complete combinationally on a hit; stores on the memory ack.
  assign bus.req_ready = w_hit_done | (w_wr & bus.mem_ack);
  assign bus.req_rdata = w_hit_done ? bus.c_rdata : '0;

  assign bus.c_tag    = w_tag;
  assign bus.c_index  = w_index;
  assign bus.c_offset = bus.req_addr[OFFSET_W-1:0];
  assign bus.c_re     = w_idle & w_load;
  assign bus.c_refill = (r_state == S_FILL);
  assign bus.c_update = w_wr & bus.mem_ack & bus.c_hit;
  assign bus.c_line   = r_line;
  assign bus.c_wdata  = bus.req_wdata;

  assign bus.mem_req   = w_wr | w_fetch;
  assign bus.mem_we    = w_wr;
  assign bus.mem_wdata = w_wr ? bus.req_wdata : '0;
  assign bus.mem_addr  =
    w_wr    ? bus.req_addr :
    w_fetch ? {w_tag, w_index, r_beat} :
              '0;

`ifdef CACHE_PERF_CNT_EN
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_done && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_miss && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif
endmodule
